// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory unit: access-kind decode,
// byte-enable generation, alignment tests and load extension.
package data_mem_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_2000;
  localparam int          WORD_BYTES        = 4;

  // RISC-V funct3 size/sign codes for loads and stores.
  localparam logic [2:0] FN3_B  = 3'b000;
  localparam logic [2:0] FN3_H  = 3'b001;
  localparam logic [2:0] FN3_W  = 3'b010;
  localparam logic [2:0] FN3_BU = 3'b100;
  localparam logic [2:0] FN3_HU = 3'b101;

  // Internal access kind; loads and stores share funct3 codes, so the
  // direction is folded in here.
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op_e;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_e;

  typedef struct packed {
    logic    legal;
    mem_op_e op;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic we, input logic [2:0] fn3);
    op_dec_t d;
    d.legal = 1'b1;
    d.op    = LW;
    if (we) begin
      case (fn3)
        FN3_B:   d.op = SB;
        FN3_H:   d.op = SH;
        FN3_W:   d.op = SW;
        default: d.legal = 1'b0;
      endcase
    end else begin
      case (fn3)
        FN3_B:   d.op = LB;
        FN3_H:   d.op = LH;
        FN3_W:   d.op = LW;
        FN3_BU:  d.op = LBU;
        FN3_HU:  d.op = LHU;
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [2:0] size_bytes(input mem_op_e op);
    case (op)
      LB, LBU, SB: return 3'd1;
      LH, LHU, SH: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return !is_store(op);
  endfunction

  // Byte enables across two consecutive words: [3:0] word k, [7:4] word k+1.
  function automatic logic [7:0] lane_be(input mem_op_e op, input logic [1:0] lane);
    logic [3:0] base;
    case (size_bytes(op))
      3'd1:    base = 4'b0001;
      3'd2:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return 8'({4'b0000, base} << lane);
  endfunction

  // Not naturally aligned for its size.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lane);
    case (size_bytes(op))
      3'd2:    return lane[0];
      3'd4:    return lane != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Touches bytes in the next word.
  function automatic logic is_crossing(input mem_op_e op, input logic [1:0] lane);
    return ({1'b0, lane} + size_bytes(op)) > 3'd4;
  endfunction

  function automatic logic [31:0] load_extend(input mem_op_e op, input logic [31:0] v);
    case (op)
      LB:      return {{24{v[7]}}, v[7:0]};
      LBU:     return {24'h0, v[7:0]};
      LH:      return {{16{v[15]}}, v[15:0]};
      LHU:     return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_byte_lane_ram.sv
// byte_lane_ram: DEPTH_WORDS x 32-bit single-port RAM, per-byte write
// enables, registered (1-cycle) read. Read-during-write returns old data.
module byte_lane_ram
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write and registered read of the addressed word.
  // NOTE: the array has no reset branch; resetting a memory turns it into
  // flops and contents must survive rst anyway.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: load/store memory slave with RISC-V size/sign codes.
// Aligned accesses respond one cycle after acceptance. Optional feature
// macro DATA_MEM_MISALIGN_SPLIT_EN: word-crossing accesses are split over
// two cycles (IDLE -> SPLIT -> IDLE) and respond two cycles after
// acceptance; without it, any misaligned access faults.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_fn3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] SPLIT = ST_SPLIT;

  logic [0:0]    state_q;

  // Request decode
  logic          accept;
  op_dec_t       dec;
  logic [31:0]   offset;
  logic [29:0]   word_idx;
  logic [1:0]    lane;
  logic          split_path;
  logic          misalign_fault;
  logic          idx_oob;
  logic          next_oob;
  logic          range_fault;
  logic          req_fault;
  logic          go_split;
  logic [7:0]    be_wide;
  logic [63:0]   wdata_wide;

  // Second-half stash and response metadata
  logic [AW-1:0] split_idx_q;
  logic [3:0]    split_be_q;
  logic [31:0]   split_wdata_q;
  logic [31:0]   lo_word_q;
  logic          rsp_valid_q;
  logic          fault_q;
  logic          split_q;
  mem_op_e       op_q;
  logic [1:0]    lane_q;

  // RAM port
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [63:0]   merged;
  logic [31:0]   aligned;

  assign req_ready = !rst && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  assign dec      = decode_op(req_we, req_fn3);
  assign offset   = req_addr - BASE_ADDR;
  assign word_idx = offset[31:2];
  assign lane     = offset[1:0];

`ifdef DATA_MEM_MISALIGN_SPLIT_EN
  // Word-crossing accesses are split; misalignment inside a word is served directly.
  assign split_path     = is_crossing(dec.op, lane);
  assign misalign_fault = 1'b0;
`else
  // Anything not naturally aligned is rejected, so SPLIT is never entered.
  assign split_path     = 1'b0;
  assign misalign_fault = is_misaligned(dec.op, lane);
`endif

  assign idx_oob     = {1'b0, word_idx} >= 31'(DEPTH_WORDS);
  assign next_oob    = ({1'b0, word_idx} + 31'd1) >= 31'(DEPTH_WORDS);
  assign range_fault = idx_oob || (split_path && next_oob);
  assign req_fault   = !dec.legal || range_fault || misalign_fault;
  assign go_split    = split_path && !req_fault;

  // Faulted requests and loads carry no enables, so memory is untouched.
  assign be_wide    = (accept && !req_fault && is_store(dec.op)) ? lane_be(dec.op, lane) : 8'h00;
  assign wdata_wide = {32'h0, req_wdata} << {lane, 3'b000};

  // State register: a split access spends exactly one cycle in SPLIT.
  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)                      state_q <= IDLE;
    else if (state_q == SPLIT)    state_q <= IDLE;
    else if (accept && go_split)  state_q <= SPLIT;
  end

  // Response pulse and metadata, captured at acceptance and held through SPLIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      split_q     <= 1'b0;
      op_q        <= LW;
      lane_q      <= 2'd0;
    end else begin
      if (state_q == SPLIT) rsp_valid_q <= 1'b1;
      else                  rsp_valid_q <= accept && !go_split;
      if (accept) begin
        fault_q <= req_fault;
        split_q <= go_split;
        op_q    <= dec.op;
        lane_q  <= lane;
      end
    end
  end

  // Second-half access for a split, and the first-half read word it merges with.
  always_ff @(posedge clk) begin
    if (accept && go_split) begin
      split_idx_q   <= word_idx[AW-1:0] + AW'(1);
      split_be_q    <= be_wide[7:4];
      split_wdata_q <= wdata_wide[63:32];
    end
    if (state_q == SPLIT) lo_word_q <= ram_rdata;
  end

  // RAM port steering: new request in IDLE, stashed second half in SPLIT.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    ram_addr  = word_idx[AW-1:0];
    ram_be    = be_wide[3:0];
    ram_wdata = wdata_wide[31:0];
    if (state_q == SPLIT) begin
      ram_addr  = split_idx_q;
      ram_be    = rst ? 4'b0000 : split_be_q;
      ram_wdata = split_wdata_q;
    end
  end

  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign merged  = split_q ? {ram_rdata, lo_word_q} : {32'h0, ram_rdata};
  assign aligned = 32'(merged >> {lane_q, 3'b000});

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_valid_q && fault_q;
  assign rsp_rdata = (rsp_valid_q && !fault_q && is_load(op_q)) ? load_extend(op_q, aligned) : 32'h0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed requests push expected
// responses (data, fault, due cycle) into a scoreboard; a monitor pops and
// compares whenever rsp_valid is seen.
module tb_data_mem_unit;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_fn3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  data_mem_unit #(
    .BASE_ADDR   (32'h8000_2000),
    .DEPTH_WORDS (4096)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_fn3   (req_fn3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int   tag_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, wanted no response", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("rdata#%0d", e.tag), rsp_rdata, e.rdata);
        check($sformatf("fault#%0d", e.tag), 32'(rsp_fault), 32'(e.fault));
        check($sformatf("latency#%0d", e.tag), cyc, e.due);
      end
    end
  end

  // Present one request (called at posedge+1); waits for ready within a bound.
  task automatic issue(input logic we, input logic [2:0] fn3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_fault, input int lat);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_fn3   = fn3;
    req_addr  = addr;
    req_wdata = wdata;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got req_ready=%b after %0d cycles, wanted 1", req_ready, n);
    end else begin
      tag_n++;
      sb_q.push_back('{exp_rdata, exp_fault, cyc + lat, tag_n});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (lat == 2) begin
      check("ready_in_split", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      check("ready_after_split", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d responses outstanding, wanted 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, wanted summary before time limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Aligned and sub-word accesses, back-to-back
    issue(1'b1, F_W,  32'h8000_2000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1);
    issue(1'b0, F_W,  32'h8000_2000, 32'h0,         32'hDEAD_BEEF, 1'b0, 1);
    issue(1'b0, F_B,  32'h8000_2003, 32'h0,         32'hFFFF_FFDE, 1'b0, 1);
    issue(1'b0, F_BU, 32'h8000_2003, 32'h0,         32'h0000_00DE, 1'b0, 1);
    issue(1'b1, F_H,  32'h8000_2002, 32'h0000_1234, 32'h0000_0000, 1'b0, 1);
    issue(1'b0, F_W,  32'h8000_2000, 32'h0,         32'h1234_BEEF, 1'b0, 1);
    issue(1'b0, F_H,  32'h8000_2000, 32'h0,         32'hFFFF_BEEF, 1'b0, 1);
    issue(1'b0, F_HU, 32'h8000_2002, 32'h0,         32'h0000_1234, 1'b0, 1);
    issue(1'b1, F_B,  32'h8000_2001, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0, 1);
    issue(1'b0, F_B,  32'h8000_2001, 32'h0,         32'h0000_005A, 1'b0, 1);
    issue(1'b0, F_W,  32'h8000_2000, 32'h0,         32'h1234_5AEF, 1'b0, 1);
    drain();

    // Range and encoding faults; memory must be untouched
    issue(1'b0, F_W,    32'h8000_1FFC, 32'h0,         32'h0, 1'b1, 1);
    issue(1'b0, F_W,    32'h8000_6000, 32'h0,         32'h0, 1'b1, 1);
    issue(1'b0, 3'b011, 32'h8000_2000, 32'h0,         32'h0, 1'b1, 1);
    issue(1'b1, 3'b011, 32'h8000_2000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    issue(1'b1, F_BU,   32'h8000_2000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    issue(1'b0, F_W,    32'h8000_2000, 32'h0,         32'h1234_5AEF, 1'b0, 1);
    issue(1'b1, F_W,    32'h8000_5FFC, 32'h1122_3344, 32'h0, 1'b0, 1);
    issue(1'b0, F_W,    32'h8000_5FFC, 32'h0,         32'h1122_3344, 1'b0, 1);
    drain();

    // Misaligned accesses
    issue(1'b1, F_W, 32'h8000_2004, 32'h0, 32'h0, 1'b0, 1);
    issue(1'b1, F_W, 32'h8000_2008, 32'h0, 32'h0, 1'b0, 1);
    issue(1'b1, F_W, 32'h8000_200C, 32'h0, 32'h0, 1'b0, 1);
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    issue(1'b1, F_W, 32'h8000_2006, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0, 2);
    issue(1'b0, F_W, 32'h8000_2006, 32'h0,         32'hA1B2_C3D4, 1'b0, 2);
    issue(1'b0, F_W, 32'h8000_2004, 32'h0,         32'hC3D4_0000, 1'b0, 1);
    issue(1'b0, F_W, 32'h8000_2008, 32'h0,         32'h0000_A1B2, 1'b0, 1);
    issue(1'b0, F_H, 32'h8000_2007, 32'h0,         32'hFFFF_B2C3, 1'b0, 2);
    issue(1'b0, F_H, 32'h8000_2005, 32'h0,         32'hFFFF_D400, 1'b0, 1);
    issue(1'b0, F_W, 32'h8000_5FFE, 32'h0,         32'h0,         1'b1, 1);
`else
    issue(1'b1, F_W, 32'h8000_2006, 32'hA1B2_C3D4, 32'h0, 1'b1, 1);
    issue(1'b0, F_W, 32'h8000_2006, 32'h0,         32'h0, 1'b1, 1);
    issue(1'b0, F_W, 32'h8000_2004, 32'h0,         32'h0, 1'b0, 1);
    issue(1'b0, F_W, 32'h8000_2008, 32'h0,         32'h0, 1'b0, 1);
    issue(1'b0, F_H, 32'h8000_2007, 32'h0,         32'h0, 1'b1, 1);
    issue(1'b0, F_H, 32'h8000_2005, 32'h0,         32'h0, 1'b1, 1);
    issue(1'b0, F_W, 32'h8000_5FFE, 32'h0,         32'h0, 1'b1, 1);
`endif
    drain();

    // Reset while a split is in flight (plain reset pulse without the feature)
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_fn3   = F_W;
    req_addr  = 32'h8000_200A;
    req_wdata = 32'hCAFE_F00D;
    check("split_rst_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`endif
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_rsp_fault", 32'(rsp_fault), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_release_ready", 32'(req_ready), 32'd1);
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    issue(1'b0, F_W, 32'h8000_2008, 32'h0, 32'hF00D_A1B2, 1'b0, 1);
`else
    issue(1'b0, F_W, 32'h8000_2008, 32'h0, 32'h0000_0000, 1'b0, 1);
`endif
    issue(1'b0, F_W, 32'h8000_200C, 32'h0, 32'h0000_0000, 1'b0, 1);
    issue(1'b0, F_W, 32'h8000_2000, 32'h0, 32'h1234_5AEF, 1'b0, 1);
    drain();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_2000: byte address mapped to memory word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096: number of 32-bit words, power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: access request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_fn3, input, 3 bits: RISC-V funct3 size/sign code.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse for every accepted request.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: load result, sign/zero-extended; 0 for stores and faults.
REQ-013 The block SHALL have port rsp_fault, output, 1 bit: access rejected; qualified by rsp_valid.

Function
REQ-014 A request SHALL be accepted when req_valid and req_ready are both 1; req_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 The state machine SHALL have two states: IDLE and SPLIT.
REQ-016 The offset SHALL be computed as req_addr - BASE_ADDR, modulo 2^32; word index = offset[31:2]; lane = offset[1:0].
REQ-017 Out-of-range accesses (word index >= DEPTH_WORDS, or for a split access word index+1 >= DEPTH_WORDS) SHALL produce rsp_fault=1, no memory write, and rsp_rdata=0.
REQ-018 The legal fn3 codes SHALL be: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Any other code SHALL fault and leave memory unmodified.
REQ-019 Storage SHALL be synchronous-read with per-byte write enables; a store SHALL write only the bytes selected by size and lane.
REQ-020 An access that does not cross a word boundary SHALL stay in IDLE and assert rsp_valid in cycle N+1, where N is the acceptance cycle; back-to-back acceptance every cycle SHALL be supported.
REQ-021 A load accepted in cycle N+1 immediately after a store to the same bytes in cycle N SHALL return the newly stored data.
REQ-022 The load result SHALL be extracted from the lane-shifted word: lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend, lw is used as-is.
REQ-023 Only one clock edge SHALL act on a given state; there is no simultaneous-request case because req_ready=0 in SPLIT.

Reset
REQ-024 While rst=1, the state SHALL go to IDLE, rsp_valid=0, rsp_fault=0, rsp_rdata=0, and any pending split SHALL be discarded.
REQ-025 Reset SHALL not clear memory contents; if rst is asserted in SPLIT, the first-half store write has already occurred and SHALL not be undone.
REQ-026 The value of req_ready SHALL be 0 in the cycle rst is sampled high, and 1 in the first cycle after rst is released.

Configuration
REQ-027 With macro DATA_MEM_MISALIGN_SPLIT_EN defined, a word-crossing access SHALL do the following:
- In cycle N, access word k.
- Enter SPLIT.
- In cycle N+1, access word k+1.
- Return to IDLE.
- Assert rsp_valid in cycle N+2 with the merged data.
REQ-028 With DATA_MEM_MISALIGN_SPLIT_EN undefined, any access misaligned for its size SHALL fault in cycle N+1 with no write, and the SPLIT state SHALL be unreachable.

Structure
REQ-029 Package data_mem_pkg SHALL hold the following:
- fn3 enum: LB, LH, LW, LBU, LHU, SB, SH, SW.
- State enum.
- Default BASE_ADDR constant.
- byte-enable/size helper functions.
REQ-030 The block SHALL have one sub-module, byte_lane_ram: DEPTH_WORDS x 32-bit RAM with 4 byte write enables and a 1-cycle registered read.

Verification
REQ-031 After reset, the bench SHALL issue sw 0xDEADBEEF @0x80002000, then lw @0x80002000; the lw SHALL give rsp_valid one cycle after acceptance, rdata=0xDEADBEEF, fault=0.
REQ-032 The bench SHALL issue lb @0x80002003 and lbu @0x80002003 after that store; the results SHALL be 0xFFFFFFDE and 0x000000DE.
REQ-033 The bench SHALL issue sh 0x1234 @0x80002002, then lw @0x80002000; the result SHALL be 0x1234BEEF, and bytes 0..1 SHALL be unchanged.
REQ-034 With DATA_MEM_MISALIGN_SPLIT_EN defined, the bench SHALL issue sw 0xA1B2C3D4 @0x80002006, then lw @0x80002006. Required response:
- req_ready=0 for one cycle.
- rsp_valid at N+2.
- rdata=0xA1B2C3D4.
Without the macro, the same access SHALL give fault=1 at N+1 and memory unchanged.
REQ-035 The bench SHALL issue lw @0x80001FFC and lw @BASE_ADDR+4*DEPTH_WORDS; both SHALL give fault=1 and rdata=0, and fn3=3'b011 SHALL fault.
REQ-036 The bench SHALL assert rst during SPLIT. Required response:
- Next cycle: rsp_valid=0.
- After release: req_ready=1.
- The following aligned lw completes normally.
